rst_seq_ctrl: RTL and testbench



---
 rtl/rst_seq_ctrl.sv | 136 +++++++++++++
 tb/tb_rst_seq_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer downstream of the MMCM: waits for a stable lock, releases the
// per-domain active-low resets in a fixed order, and services software resets in RUN.
module rst_seq_ctrl #(
    parameter int LOCK_STABLE_CYC = 64,
    parameter int STAGE_GAP_CYC   = 16,
    parameter int SW_RST_CYC      = 32
) (
    input  logic       sys_clk_i,
    input  logic       sys_rst_i,
    input  logic       locked_i,
    input  logic [4:0] sw_rst_req_i,
    output logic       per_rstn_o,
    output logic       dma_rstn_o,
    output logic       dla_rstn_o,
    output logic       riscv_debug_rstn_o,
    output logic       riscv_core_rstn_o,
    output logic       rst_done_o,
    output logic       lock_lost_o,
    output logic [1:0] state_o
);

    localparam int LW = $clog2(LOCK_STABLE_CYC + 1);
    localparam int GW = $clog2(STAGE_GAP_CYC + 1);
    localparam int SW = $clog2(SW_RST_CYC + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STABLE  = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } state_t;

    state_t         state;
    logic [1:0]     sync;
    logic           lk;
    logic [LW-1:0]  lock_cnt;
    logic [GW-1:0]  gap_cnt;
    logic [2:0]     stage;
    logic [4:0]     rstn;
    logic           rst_done;
    logic           lock_lost;
    logic [SW-1:0]  sw_cnt [5];

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            sync <= '0;
        end else begin
            sync <= {sync[0], locked_i};
        end
    end

    assign lk = sync[1];

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state     <= IDLE;
            lock_cnt  <= '0;
            gap_cnt   <= '0;
            stage     <= '0;
            rstn      <= '0;
            rst_done  <= 1'b0;
            lock_lost <= 1'b0;
            // NOTE: the counter array is cleared element by element; it is a handful of
            // flops, not a RAM, so resetting it costs nothing and keeps RUN entry clean.
            for (int i = 0; i < 5; i++) sw_cnt[i] <= '0;
        end else if (!lk && (state == RELEASE || state == RUN)) begin
            // Lock loss outranks any software request seen in the same cycle.
            state     <= IDLE;
            lock_cnt  <= '0;
            gap_cnt   <= '0;
            stage     <= '0;
            rstn      <= '0;
            rst_done  <= 1'b0;
            lock_lost <= 1'b1;
            for (int i = 0; i < 5; i++) sw_cnt[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rstn <= '0;
                    if (lk) begin
                        state    <= STABLE;
                        lock_cnt <= LW'(1);
                    end
                end
                STABLE: begin
                    if (!lk) begin
                        state    <= IDLE;
                        lock_cnt <= '0;
                    end else if (lock_cnt == LW'(LOCK_STABLE_CYC)) begin
                        state   <= RELEASE;
                        rstn[0] <= 1'b1;
                        gap_cnt <= '0;
                        stage   <= 3'd1;
                    end else begin
                        lock_cnt <= lock_cnt + LW'(1);
                    end
                end
                RELEASE: begin
                    if (stage == 3'd5) begin
                        state    <= RUN;
                        rst_done <= 1'b1;
                    end else if (gap_cnt == GW'(STAGE_GAP_CYC - 1)) begin
                        rstn[stage] <= 1'b1;
                        stage       <= stage + 3'd1;
                        gap_cnt     <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                RUN: begin
                    // A domain comes back high on the edge its counter reaches zero.
                    for (int i = 0; i < 5; i++) begin
                        if (sw_rst_req_i[i]) begin
                            sw_cnt[i] <= SW'(SW_RST_CYC);
                            rstn[i]   <= 1'b0;
                        end else if (sw_cnt[i] != '0) begin
                            sw_cnt[i] <= sw_cnt[i] - SW'(1);
                            if (sw_cnt[i] == SW'(1)) rstn[i] <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign per_rstn_o         = rstn[0];
    assign dma_rstn_o         = rstn[1];
    assign dla_rstn_o         = rstn[2];
    assign riscv_debug_rstn_o = rstn[3];
    assign riscv_core_rstn_o  = rstn[4];
    assign rst_done_o         = rst_done;
    assign lock_lost_o        = lock_lost;
    assign state_o            = state;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl: power-up ordering, software resets, lock loss,
// sync reset mid-RUN and a glitchy lock, with hand-computed cycle positions.
module tb_rst_seq_ctrl;

    logic       clk = 1'b0;
    logic       sys_rst;
    logic       locked;
    logic [4:0] sw_req;
    logic       per_rstn, dma_rstn, dla_rstn, dbg_rstn, core_rstn;
    logic       rst_done, lock_lost;
    logic [1:0] state;

    int cyc = 0;
    int n0  = 0;
    int n_checks = 0;
    int n_pass   = 0;

    rst_seq_ctrl dut (
        .sys_clk_i          (clk),
        .sys_rst_i          (sys_rst),
        .locked_i           (locked),
        .sw_rst_req_i       (sw_req),
        .per_rstn_o         (per_rstn),
        .dma_rstn_o         (dma_rstn),
        .dla_rstn_o         (dla_rstn),
        .riscv_debug_rstn_o (dbg_rstn),
        .riscv_core_rstn_o  (core_rstn),
        .rst_done_o         (rst_done),
        .lock_lost_o        (lock_lost),
        .state_o            (state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Observed vector is {lock_lost, rst_done, state, rstn[4:0]}.
    task automatic expect_out(input string tag, input logic [4:0] r, input logic d,
                              input logic l, input logic [1:0] s);
        check(tag, {23'd0, lock_lost, rst_done, state,
                    core_rstn, dbg_rstn, dla_rstn, dma_rstn, per_rstn},
              {23'd0, l, d, s, r});
    endtask

    // Called at a negedge; returns at the negedge following posedge n0+t.
    task automatic goto(input int t);
        repeat (n0 + t - cyc) @(negedge clk);
    endtask

    task automatic mark;
        n0 = cyc + 1;
    endtask

    initial begin
        sys_rst = 1'b1;
        locked  = 1'b0;
        sw_req  = '0;
        repeat (3) @(negedge clk);
        expect_out("reset", 5'b00000, 1'b0, 1'b0, 2'd0);
        sys_rst = 1'b0;
        repeat (3) @(negedge clk);
        expect_out("idle_nolock", 5'b00000, 1'b0, 1'b0, 2'd0);

        // Power-up with all software requests held outside RUN.
        locked = 1'b1;
        sw_req = 5'b11111;
        mark();
        goto(1);   expect_out("pu_n1_idle", 5'b00000, 1'b0, 1'b0, 2'd0);
        goto(2);   expect_out("pu_n2_stable", 5'b00000, 1'b0, 1'b0, 2'd1);
        goto(65);  expect_out("pu_n65_stable", 5'b00000, 1'b0, 1'b0, 2'd1);
        goto(66);  expect_out("pu_n66_per", 5'b00001, 1'b0, 1'b0, 2'd2);
        goto(81);  expect_out("pu_n81", 5'b00001, 1'b0, 1'b0, 2'd2);
        goto(82);  expect_out("pu_n82_dma", 5'b00011, 1'b0, 1'b0, 2'd2);
        goto(98);  expect_out("pu_n98_dla", 5'b00111, 1'b0, 1'b0, 2'd2);
        goto(113); expect_out("pu_n113", 5'b00111, 1'b0, 1'b0, 2'd2);
        goto(114); expect_out("pu_n114_dbg", 5'b01111, 1'b0, 1'b0, 2'd2);
        goto(130); expect_out("pu_n130_core", 5'b11111, 1'b0, 1'b0, 2'd2);
        sw_req = '0;
        goto(131); expect_out("pu_n131_run", 5'b11111, 1'b1, 1'b0, 2'd3);
        goto(135);

        // Software reset of riscv_core only; riscv_debug untouched.
        sw_req = 5'b10000; mark();
        goto(0);  sw_req = '0;
        expect_out("sw_core_low", 5'b01111, 1'b1, 1'b0, 2'd3);
        goto(31); expect_out("sw_core_m31", 5'b01111, 1'b1, 1'b0, 2'd3);
        goto(32); expect_out("sw_core_m32", 5'b11111, 1'b1, 1'b0, 2'd3);

        // Two domains in one cycle.
        sw_req = 5'b00011; mark();
        goto(0);  sw_req = '0;
        expect_out("sw_multi_low", 5'b11100, 1'b1, 1'b0, 2'd3);
        goto(32); expect_out("sw_multi_high", 5'b11111, 1'b1, 1'b0, 2'd3);

        // dla reset extended by a second request 20 cycles in.
        sw_req = 5'b00100; mark();
        goto(0);  sw_req = '0;
        expect_out("sw_dla_low", 5'b11011, 1'b1, 1'b0, 2'd3);
        goto(19); sw_req = 5'b00100;
        goto(20); sw_req = '0;
        goto(32); expect_out("sw_dla_ext32", 5'b11011, 1'b1, 1'b0, 2'd3);
        goto(51); expect_out("sw_dla_ext51", 5'b11011, 1'b1, 1'b0, 2'd3);
        goto(52); expect_out("sw_dla_ext52", 5'b11111, 1'b1, 1'b0, 2'd3);
        goto(55);

        // Lock loss in RUN coinciding with a software request.
        locked = 1'b0; mark();
        goto(1);  expect_out("ll_run_l1", 5'b11111, 1'b1, 1'b0, 2'd3);
        sw_req = 5'b00001;
        goto(2);  sw_req = '0;
        expect_out("ll_run_l2", 5'b00000, 1'b0, 1'b1, 2'd0);
        goto(6);  expect_out("ll_run_hold", 5'b00000, 1'b0, 1'b1, 2'd0);

        // Re-lock, then lose lock after the dma release.
        locked = 1'b1; mark();
        goto(66); expect_out("rl_per", 5'b00001, 1'b0, 1'b1, 2'd2);
        goto(82); expect_out("rl_dma", 5'b00011, 1'b0, 1'b1, 2'd2);
        goto(85); locked = 1'b0;
        goto(87); expect_out("ll_rel_pre", 5'b00011, 1'b0, 1'b1, 2'd2);
        goto(88); expect_out("ll_rel_drop", 5'b00000, 1'b0, 1'b1, 2'd0);
        goto(90);

        // Full re-release keeps the sticky flag.
        locked = 1'b1; mark();
        goto(131); expect_out("rl_run_sticky", 5'b11111, 1'b1, 1'b1, 2'd3);
        goto(135);

        // Sync reset in RUN while a dla software reset is active.
        sw_req = 5'b00100; mark();
        goto(0);  sw_req = '0;
        goto(5);  expect_out("sr_sw_active", 5'b11011, 1'b1, 1'b1, 2'd3);
        sys_rst = 1'b1; mark();
        goto(0);  sys_rst = 1'b0;
        expect_out("sr_reset", 5'b00000, 1'b0, 1'b0, 2'd0);
        goto(2);  expect_out("sr_r2_idle", 5'b00000, 1'b0, 1'b0, 2'd0);
        goto(3);  expect_out("sr_r3_stable", 5'b00000, 1'b0, 1'b0, 2'd1);
        goto(66); expect_out("sr_r66", 5'b00000, 1'b0, 1'b0, 2'd1);
        goto(67); expect_out("sr_r67_per", 5'b00001, 1'b0, 1'b0, 2'd2);

        // Clean restart with lock low, then a glitchy lock.
        locked  = 1'b0;
        sys_rst = 1'b1;
        @(negedge clk);
        sys_rst = 1'b0;
        repeat (4) @(negedge clk);
        locked = 1'b1; mark();
        goto(39);  locked = 1'b0;
        goto(41);  expect_out("gl_n41_stable", 5'b00000, 1'b0, 1'b0, 2'd1);
        goto(42);  expect_out("gl_n42_idle", 5'b00000, 1'b0, 1'b0, 2'd0);
        locked = 1'b1;
        goto(44);  expect_out("gl_n44_idle", 5'b00000, 1'b0, 1'b0, 2'd0);
        goto(45);  expect_out("gl_n45_stable", 5'b00000, 1'b0, 1'b0, 2'd1);
        goto(108); expect_out("gl_n108", 5'b00000, 1'b0, 1'b0, 2'd1);
        goto(109); expect_out("gl_n109_per", 5'b00001, 1'b0, 1'b0, 2'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
